mining_work_scheduler: RTL and testbench
========================================

Name: mining_work_scheduler

Overview:
- Sequences work for the SHA-256d mining core: accepts new work (midstate + data2) from the host through a valid/ready handshake and holds one entry pending.
- Drives the active work onto the core and counts the core's nonce sweep until it is exhausted.
- Swaps in pending work with no idle cycles, and tags each golden nonce with the work ID that produced it.
- Buffers results in a small FIFO for the host. Sits between the host virtual-wire/bus interface and fpgaminer_core.

Parameters:
- LOOP_LOG2, 0: core unroll factor; the core covers 2^(32-LOOP_LOG2) cycles per full nonce sweep.
- PIPE_LATENCY, 67: cycles from a core work change until the core can no longer report golden nonces for the old work.
- FIFO_DEPTH, 4: result FIFO entries; must be a power of 2 and at least 2.
- WORK_ID_W, 2: width of the work tag.

Ports:
- clk  in  1  hash clock
- reset  in  1  asynchronous, active-high reset
- work_valid  in  1  host offers work
- work_ready  out  1  scheduler can accept work
- work_midstate  in  256  offered midstate
- work_data2  in  256  offered data2
- core_midstate  out  256  active midstate to core
- core_data2  out  256  active data2 to core
- core_load  out  1  one-cycle pulse: core restarts its nonce at 0
- core_golden_valid  in  1  core found a golden nonce this cycle
- core_golden_nonce  in  32  the golden nonce
- result_valid  out  1  FIFO not empty
- result_ready  in  1  host pops a result
- result_nonce  out  32  head nonce
- result_work_id  out  WORK_ID_W  head tag
- need_work  out  1  high in IDLE and in EXHAUSTED
- overflow  out  1  sticky; a result was dropped
- active_id  out  WORK_ID_W  tag of the work currently on the core

Behaviour:
- Reset values:
  - all outputs 0 except work_ready=1 and need_work=1;
  - state IDLE, pending empty, sweep counter 0, drain counter 0, next_id 0.
- Accept: work_valid && work_ready latches the work into the pending register and tags it with next_id; next_id increments modulo 2^WORK_ID_W.
  - work_ready = !pending_full.
- Load: pending moves to active. In the same edge:
  - core_midstate/core_data2/active_id update;
  - core_load pulses high for exactly 1 cycle;
  - the sweep counter (width 32-LOOP_LOG2) clears;
  - prev_id <= old active_id;
  - drain counter <= PIPE_LATENCY;
  - pending empties.
- State IDLE: if pending is full, load and go to RUN. Accept-to-load latency is 1 cycle (accept at edge N, load at N+1).
- State RUN: the sweep counter increments every cycle. At the terminal count (all ones):
  - pending full: load and stay in RUN (back-to-back, no gap);
  - pending empty: go to EXHAUSTED and hold the counter.
- State EXHAUSTED: when pending becomes full, load and go to RUN.
- Simultaneous events: an accept in the same cycle as the terminal count does not count as pending that cycle. The load happens on the next edge, in EXHAUSTED.
- Golden tagging when core_golden_valid:
  - drain counter != 0: tag = prev_id;
  - else in RUN: tag = active_id;
  - else (IDLE, or EXHAUSTED with drain 0): discard; this is not an overflow.
  - The drain counter decrements to 0 every cycle regardless of state.
- Result FIFO:
  - push on a tagged golden result; pop on result_valid && result_ready; first-word fall-through (head is visible on result_nonce/result_work_id while result_valid).
  - Full, push without pop: drop the new entry and set overflow.
  - Full, push with pop: both happen; count unchanged; no overflow.
  - Empty: a push becomes visible the next cycle.
- Reset mid-operation: asynchronously returns everything to reset values. FIFO contents and pending work are lost. core_load is not pulsed by reset.

Decomposition:
- Package miner_ctrl_pkg:
  - state enum {IDLE, RUN, EXHAUSTED};
  - NONCE_W=32, MIDSTATE_W=256, DATA2_W=256;
  - result struct {nonce, work_id}.
- Sub-module golden_result_fifo: parameterised depth/width, with push/pop/full/empty and drop-on-full plus overflow flag.

Test Plan:
- Reset, then one work offered (midstate=A, data2=B):
  - work_ready high during the accept;
  - core_load pulses 1 cycle later;
  - core_midstate=A, active_id=0, need_work=0.
- LOOP_LOG2=24 (256-cycle sweep), second work offered early:
  - load occurs exactly at cycle 256 after the first load;
  - active_id=1; no gap cycle; work_ready returns to 1.
- Same sweep, no second work:
  - EXHAUSTED at cycle 256; need_work=1;
  - golden pulse 10 cycles after the terminal count with PIPE_LATENCY=67 is discarded;
  - new work then gives core_load 1 cycle after accept.
- Golden nonce 0x1234_5678 asserted 5 cycles after a switch from id 0 to id 1: result_work_id=0.
  - Same nonce 80 cycles after the switch: result_work_id=1.
- FIFO_DEPTH=4, result_ready=0, 5 golden pulses in RUN:
  - 4 stored in order; overflow=1;
  - then a push and a pop in the same cycle keep the count at 4 with overflow unchanged.
- Async reset asserted mid-RUN with 2 results queued:
  - result_valid=0 and need_work=1 immediately, without waiting for a clk edge;
  - next work gets active_id=0.

Source files
------------

// File: rtl/miner_ctrl_pkg.sv
// Shared types and widths for the mining work scheduler and its result FIFO.
package miner_ctrl_pkg;

    localparam int unsigned NONCE_W       = 32;
    localparam int unsigned MIDSTATE_W    = 256;
    localparam int unsigned DATA2_W       = 256;
    localparam int unsigned WORK_ID_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXHAUSTED
    } state_t;

    // work_id is sized for the widest supported tag; the top narrows it.
    typedef struct packed {
        logic [NONCE_W-1:0]       nonce;
        logic [WORK_ID_MAX_W-1:0] work_id;
    } result_t;

endpackage

// File: rtl/golden_result_fifo.sv
// First-word fall-through result FIFO; a push while full without a pop is
// dropped and latches the sticky overflow flag.
module golden_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W+1)'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mining_work_scheduler.sv
// Holds one pending work item, sweeps the active one on the core, swaps work
// back-to-back and tags golden nonces with the work ID that produced them.
module mining_work_scheduler
    import miner_ctrl_pkg::*;
#(
    parameter int unsigned LOOP_LOG2    = 0,
    parameter int unsigned PIPE_LATENCY = 67,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned WORK_ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  work_valid,
    output logic                  work_ready,
    input  logic [MIDSTATE_W-1:0] work_midstate,
    input  logic [DATA2_W-1:0]    work_data2,
    output logic [MIDSTATE_W-1:0] core_midstate,
    output logic [DATA2_W-1:0]    core_data2,
    output logic                  core_load,
    input  logic                  core_golden_valid,
    input  logic [NONCE_W-1:0]    core_golden_nonce,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [NONCE_W-1:0]    result_nonce,
    output logic [WORK_ID_W-1:0]  result_work_id,
    output logic                  need_work,
    output logic                  overflow,
    output logic [WORK_ID_W-1:0]  active_id
);

    localparam int unsigned SWEEP_W = NONCE_W - LOOP_LOG2;
    localparam int unsigned DRAIN_W = (PIPE_LATENCY < 1) ? 1 : $clog2(PIPE_LATENCY + 1);

    state_t                state;
    state_t                state_nx;
    logic                  load;
    logic                  accept;
    logic                  sweep_term;
    logic [SWEEP_W-1:0]    sweep_cnt;
    logic [DRAIN_W-1:0]    drain_cnt;

    logic                  pend_full;
    logic [MIDSTATE_W-1:0] pend_midstate;
    logic [DATA2_W-1:0]    pend_data2;
    logic [WORK_ID_W-1:0]  pend_id;
    logic [WORK_ID_W-1:0]  next_id;
    logic [WORK_ID_W-1:0]  prev_id;

    logic                  tag_valid;
    logic [WORK_ID_W-1:0]  tag_id;
    result_t               push_res;
    result_t               head_res;
    logic                  fifo_empty;

    assign work_ready = !pend_full;
    assign accept     = work_valid && !pend_full;
    assign need_work  = (state == IDLE) || (state == EXHAUSTED);
    assign sweep_term = &sweep_cnt;

    // pend_full is the registered flag, so work accepted on the terminal
    // cycle is only seen as pending on the following cycle.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (sweep_term) begin
                    if (pend_full) begin
                        load = 1'b1;
                    end else begin
                        state_nx = EXHAUSTED;
                    end
                end
            end
            EXHAUSTED: begin
                if (pend_full) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            core_load <= 1'b0;
        end else begin
            state     <= state_nx;
            core_load <= load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full     <= 1'b0;
            pend_midstate <= '0;
            pend_data2    <= '0;
            pend_id       <= '0;
            next_id       <= '0;
        end else if (accept) begin
            pend_full     <= 1'b1;
            pend_midstate <= work_midstate;
            pend_data2    <= work_data2;
            pend_id       <= next_id;
            next_id       <= next_id + WORK_ID_W'(1);
        end else if (load) begin
            pend_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_midstate <= '0;
            core_data2    <= '0;
            active_id     <= '0;
            prev_id       <= '0;
            sweep_cnt     <= '0;
            drain_cnt     <= '0;
        end else if (load) begin
            core_midstate <= pend_midstate;
            core_data2    <= pend_data2;
            active_id     <= pend_id;
            prev_id       <= active_id;
            sweep_cnt     <= '0;
            drain_cnt     <= DRAIN_W'(PIPE_LATENCY);
        end else begin
            if (state == RUN && !sweep_term) begin
                sweep_cnt <= sweep_cnt + SWEEP_W'(1);
            end
            if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    // While the old work drains out of the core pipeline its results keep
    // the previous tag; outside RUN with nothing draining they are stale.
    always_comb begin
        tag_valid = 1'b0;
        tag_id    = active_id;
        if (core_golden_valid) begin
            if (drain_cnt != '0) begin
                tag_valid = 1'b1;
                tag_id    = prev_id;
            end else if (state == RUN) begin
                tag_valid = 1'b1;
            end
        end
        push_res.nonce   = core_golden_nonce;
        push_res.work_id = WORK_ID_MAX_W'(tag_id);
    end

    golden_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(result_t))
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_valid),
        .push_data (push_res),
        .pop       (result_ready),
        .head      (head_res),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign result_valid   = !fifo_empty;
    assign result_nonce   = head_res.nonce;
    assign result_work_id = WORK_ID_W'(head_res.work_id);

endmodule

// File: tb/tb_mining_work_scheduler.sv
// Randomized and directed bench for mining_work_scheduler against a queue-based
// behavioural model of work hand-off, sweep length and result tagging.
module tb_mining_work_scheduler;
    import miner_ctrl_pkg::*;

    localparam int unsigned LOOP_LOG2    = 24;
    localparam int unsigned PIPE_LATENCY = 67;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned WORK_ID_W    = 2;
    localparam int          SWEEP        = 1 << (32 - LOOP_LOG2);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  work_valid;
    logic                  work_ready;
    logic [MIDSTATE_W-1:0] work_midstate;
    logic [DATA2_W-1:0]    work_data2;
    logic [MIDSTATE_W-1:0] core_midstate;
    logic [DATA2_W-1:0]    core_data2;
    logic                  core_load;
    logic                  core_golden_valid;
    logic [NONCE_W-1:0]    core_golden_nonce;
    logic                  result_valid;
    logic                  result_ready;
    logic [NONCE_W-1:0]    result_nonce;
    logic [WORK_ID_W-1:0]  result_work_id;
    logic                  need_work;
    logic                  overflow;
    logic [WORK_ID_W-1:0]  active_id;

    always #5 clk = ~clk;

    mining_work_scheduler #(
        .LOOP_LOG2    (LOOP_LOG2),
        .PIPE_LATENCY (PIPE_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .WORK_ID_W    (WORK_ID_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .work_valid        (work_valid),
        .work_ready        (work_ready),
        .work_midstate     (work_midstate),
        .work_data2        (work_data2),
        .core_midstate     (core_midstate),
        .core_data2        (core_data2),
        .core_load         (core_load),
        .core_golden_valid (core_golden_valid),
        .core_golden_nonce (core_golden_nonce),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_nonce      (result_nonce),
        .result_work_id    (result_work_id),
        .need_work         (need_work),
        .overflow          (overflow),
        .active_id         (active_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: pending work and results are queues; the sweep is a
    // position within a SWEEP-cycle window; draining is time since the last load.
    typedef struct {
        logic [255:0] ms;
        logic [255:0] d2;
        int           id;
    } work_t;
    typedef struct {
        logic [31:0] nonce;
        int          id;
    } res_t;

    work_t        m_pend[$];
    res_t         m_res[$];
    bit           m_running;
    int           m_pos;
    int           m_since;
    int           m_cur;
    int           m_old;
    int           m_next_tag;
    bit           m_ovf;
    bit           m_load;
    logic [255:0] m_ms;
    logic [255:0] m_d2;

    task automatic m_reset();
        m_pend.delete();
        m_res.delete();
        m_running  = 1'b0;
        m_pos      = 0;
        m_since    = 1000000;
        m_cur      = 0;
        m_old      = 0;
        m_next_tag = 0;
        m_ovf      = 1'b0;
        m_load     = 1'b0;
        m_ms       = '0;
        m_d2       = '0;
    endtask

    task automatic model_step();
        bit    pend;
        bit    term;
        bit    gpush;
        bit    pop;
        int    gtag;
        int    sz;
        work_t w;
        pend  = (m_pend.size() != 0);
        sz    = m_res.size();
        gpush = 1'b0;
        gtag  = 0;
        if (core_golden_valid) begin
            if (m_since < PIPE_LATENCY) begin
                gpush = 1'b1;
                gtag  = m_old;
            end else if (m_running) begin
                gpush = 1'b1;
                gtag  = m_cur;
            end
        end
        pop = result_ready && (sz > 0);
        if (pop) m_res.delete(0);
        if (gpush) begin
            if (sz == FIFO_DEPTH && !pop) m_ovf = 1'b1;
            else m_res.push_back('{core_golden_nonce, gtag});
        end
        term   = m_running && (m_pos == SWEEP - 1);
        m_load = pend && (!m_running || term);
        if (m_load) begin
            w = m_pend[0];
            m_pend.delete(0);
            m_old     = m_cur;
            m_cur     = w.id;
            m_ms      = w.ms;
            m_d2      = w.d2;
            m_running = 1'b1;
            m_pos     = 0;
            m_since   = 0;
        end else begin
            if (term) m_running = 1'b0;
            else if (m_running) m_pos++;
            if (m_since < 1000000) m_since++;
        end
        if (work_valid && !pend) begin
            m_pend.push_back('{work_midstate, work_data2, m_next_tag});
            m_next_tag = (m_next_tag + 1) % (1 << WORK_ID_W);
        end
    endtask

    task automatic compare_all();
        chk("work_ready", work_ready, m_pend.size() == 0);
        chk("need_work", need_work, !m_running);
        chk("core_load", core_load, m_load);
        chk("core_midstate", core_midstate, m_ms);
        chk("core_data2", core_data2, m_d2);
        chk("active_id", active_id, m_cur);
        chk("result_valid", result_valid, m_res.size() != 0);
        if (m_res.size() != 0) begin
            chk("result_nonce", result_nonce, m_res[0].nonce);
            chk("result_work_id", result_work_id, m_res[0].id);
        end
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int unsigned i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        work_valid        = 1'b0;
        core_golden_valid = 1'b0;
        core_golden_nonce = '0;
        result_ready      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic offer(input logic [255:0] ms, input logic [255:0] d2);
        work_valid    = 1'b1;
        work_midstate = ms;
        work_data2    = d2;
        cycle();
        work_valid = 1'b0;
    endtask

    task automatic golden(input logic [31:0] n, input logic rr);
        core_golden_valid = 1'b1;
        core_golden_nonce = n;
        result_ready      = rr;
        cycle();
        core_golden_valid = 1'b0;
        result_ready      = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [255:0] a;
        logic [255:0] b;
        int           k;

        reset = 1'b1;
        idle_inputs();
        work_midstate = '0;
        work_data2    = '0;
        m_reset();

        // Reset state and first accept/load.
        do_reset();
        compare_all();
        chk("reset_need_work", need_work, 1'b1);
        a = rand256();
        b = rand256();
        chk("ready_at_accept", work_ready, 1'b1);
        offer(a, b);
        cycle();
        chk("first_load", core_load, 1'b1);
        chk("first_midstate", core_midstate, a);
        chk("first_id", active_id, 0);
        chk("first_need_work", need_work, 1'b0);

        // Second work offered early: back-to-back swap at the terminal count.
        offer(rand256(), rand256());
        k = 1;
        while (k < 300) begin
            cycle();
            k++;
            if (core_load) break;
        end
        chk("b2b_load_cycle", k, SWEEP);
        chk("b2b_id", active_id, 1);
        chk("b2b_ready", work_ready, 1'b1);

        // Tagging across the 0 -> 1 switch.
        k = 0;
        repeat (5) begin cycle(); k++; end
        golden(32'h1234_5678, 1'b0);
        k++;
        chk("drain_tag_id", result_work_id, 0);
        chk("drain_tag_nonce", result_nonce, 32'h1234_5678);
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        k++;
        while (k < 80) begin cycle(); k++; end
        golden(32'h1234_5678, 1'b0);
        k++;
        chk("post_drain_tag_id", result_work_id, 1);
        result_ready = 1'b1;
        cycle();
        result_ready = 1'b0;
        k++;

        // No further work: exhaust, discard a stale golden, then restart.
        while (!need_work && k < 400) begin cycle(); k++; end
        chk("exhaust_cycle", k, SWEEP);
        repeat (9) cycle();
        golden(32'hdead_beef, 1'b0);
        chk("exhausted_discard", result_valid, 1'b0);
        chk("exhausted_no_ovf", overflow, 1'b0);
        offer(rand256(), rand256());
        cycle();
        chk("restart_load", core_load, 1'b1);
        chk("restart_id", active_id, 2);

        // FIFO full behaviour in RUN after the drain window.
        repeat (70) cycle();
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) golden(32'ha000_0000 + i, 1'b0);
        golden(32'hb000_0000, 1'b1);
        chk("full_pushpop_no_ovf", overflow, 1'b0);
        golden(32'hc000_0000, 1'b0);
        chk("full_drop_ovf", overflow, 1'b1);
        golden(32'hd000_0000, 1'b1);
        chk("full_pushpop_ovf_kept", overflow, 1'b1);
        result_ready = 1'b1;
        k = 0;
        while (result_valid && k < 10) begin cycle(); k++; end
        result_ready = 1'b0;
        chk("full_count", k, FIFO_DEPTH);

        // Randomized traffic.
        do_reset();
        compare_all();
        for (int i = 0; i < 3000; i++) begin
            if (((i / 500) % 2) == 1) work_valid = ($urandom_range(0, 2) == 0);
            else work_valid = ($urandom_range(0, 299) == 0);
            work_midstate     = rand256();
            work_data2        = rand256();
            core_golden_valid = ($urandom_range(0, 5) == 0);
            core_golden_nonce = $urandom;
            result_ready      = (((i / 200) % 3) != 0) && ($urandom_range(0, 1) == 1);
            cycle();
        end
        idle_inputs();

        // Asynchronous reset mid-RUN with results queued.
        do_reset();
        offer(rand256(), rand256());
        cycle();
        repeat (80) cycle();
        golden(32'h0000_0011, 1'b0);
        golden(32'h0000_0022, 1'b0);
        chk("pre_reset_valid", result_valid, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_result_valid", result_valid, 1'b0);
        chk("async_need_work", need_work, 1'b1);
        chk("async_work_ready", work_ready, 1'b1);
        chk("async_core_load", core_load, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_reset();
        compare_all();
        offer(rand256(), rand256());
        cycle();
        chk("post_reset_load", core_load, 1'b1);
        chk("post_reset_id", active_id, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
